// File: rtl/servo_pwm_decoder.sv
// Hobby-servo PWM receiver: measures high time and frame period, then divides the high time down to an 8-bit angle.
// Define PWM_DEC_GLITCH_FILTER_EN to insert a FILTER_LEN-deep glitch filter ahead of the edge detector.
module servo_pwm_decoder #(
    parameter int unsigned MIN_WIDTH  = 50000,
    parameter int unsigned MAX_WIDTH  = 100000,
    parameter int unsigned PERIOD_MIN = 900000,
    parameter int unsigned PERIOD_MAX = 1100000,
    parameter int unsigned TIMEOUT    = 2000000,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [7:0]  angle,
    output logic [19:0] pulse_width,
    output logic [20:0] period,
    output logic        sample_valid,
    output logic        range_err,
    output logic        frame_err,
    output logic        signal_lost
);

    localparam logic [19:0] MIN_W = 20'(MIN_WIDTH);
    localparam logic [19:0] SPAN  = 20'(MAX_WIDTH - MIN_WIDTH);
    localparam logic [20:0] P_MIN = 21'(PERIOD_MIN);
    localparam logic [20:0] P_MAX = 21'(PERIOD_MAX);
    localparam logic [20:0] T_OUT = 21'(TIMEOUT);

    typedef enum logic [1:0] {WAIT_RISE, HIGH, LOW} state_t;

    logic sync1, sync2, lvl, lvl_d, rise, fall;

    // NOTE: registers are written with <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            lvl_d <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            lvl_d <= lvl;
            rise  <= lvl & ~lvl_d;
            fall  <= ~lvl & lvl_d;
        end
    end

`ifdef PWM_DEC_GLITCH_FILTER_EN
    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);

    logic           filt;
    logic [FCW-1:0] fcnt;

    // The filtered level follows only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= 1'b0;
            fcnt <= '0;
        end else if (sync2 == filt) begin
            fcnt <= '0;
        end else if (fcnt == FCW'(FILTER_LEN - 1)) begin
            filt <= sync2;
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + FCW'(1);
        end
    end

    assign lvl = filt;
`else
    // FILTER_LEN has no effect without the filter.
    logic [31:0] unused_filter_len;
    assign unused_filter_len = 32'(FILTER_LEN);
    assign lvl = sync2;
`endif

    state_t      state;
    logic [19:0] high_cnt;
    logic [20:0] period_cnt;
    logic        div_busy;
    logic [4:0]  div_cnt;
    logic [19:0] div_rem;
    logic [27:0] div_quo;
    logic        div_under;
    logic [19:0] div_w;
    logic [20:0] div_p;

    logic [19:0] high_inc;
    logic [20:0] per_inc;
    logic [20:0] rem_sh;
    logic        take;
    logic [19:0] rem_nxt;
    logic [27:0] quo_nxt;
    logic [27:0] num;
    logic        period_ok;
    logic        timeout_hit;

    // NOTE: every signal gets a value on every path through always_comb, so no latch can be inferred.
    always_comb begin
        high_inc    = (&high_cnt) ? high_cnt : high_cnt + 20'd1;
        per_inc     = (&period_cnt) ? period_cnt : period_cnt + 21'd1;
        rem_sh      = {div_rem, div_quo[27]};
        take        = rem_sh >= {1'b0, SPAN};
        rem_nxt     = take ? 20'(rem_sh - {1'b0, SPAN}) : rem_sh[19:0];
        quo_nxt     = {div_quo[26:0], take};
        num         = (high_cnt >= MIN_W) ? 28'(high_cnt - MIN_W) * 28'd180 : '0;
        period_ok   = (period_cnt >= P_MIN) && (period_cnt <= P_MAX);
        timeout_hit = ((state == HIGH) || (state == LOW && !rise)) && (per_inc >= T_OUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WAIT_RISE;
            high_cnt     <= '0;
            period_cnt   <= '0;
            div_busy     <= 1'b0;
            div_cnt      <= '0;
            div_rem      <= '0;
            div_quo      <= '0;
            div_under    <= 1'b0;
            div_w        <= '0;
            div_p        <= '0;
            angle        <= '0;
            pulse_width  <= '0;
            period       <= '0;
            sample_valid <= 1'b0;
            range_err    <= 1'b0;
            frame_err    <= 1'b0;
            signal_lost  <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;

            // One restoring shift-subtract step per cycle; the last step publishes the frame.
            if (div_busy && !timeout_hit) begin
                div_rem <= rem_nxt;
                div_quo <= quo_nxt;
                div_cnt <= div_cnt - 5'd1;
                if (div_cnt == 5'd0) begin
                    div_busy     <= 1'b0;
                    sample_valid <= 1'b1;
                    pulse_width  <= div_w;
                    period       <= div_p;
                    if (div_under) begin
                        angle     <= 8'd0;
                        range_err <= 1'b1;
                    end else if (|quo_nxt[27:8]) begin
                        angle     <= 8'hFF;
                        range_err <= 1'b1;
                    end else begin
                        angle       <= quo_nxt[7:0];
                        range_err   <= 1'b0;
                        signal_lost <= 1'b0;
                    end
                end
            end

            case (state)
                WAIT_RISE: begin
                    high_cnt   <= '0;
                    period_cnt <= '0;
                    if (rise) begin
                        state      <= HIGH;
                        high_cnt   <= 20'd1;
                        period_cnt <= 21'd1;
                    end
                end
                HIGH: begin
                    period_cnt <= per_inc;
                    if (fall) state <= LOW;
                    else      high_cnt <= high_inc;
                end
                LOW: begin
                    if (rise) begin
                        if (div_busy) begin
                            frame_err <= 1'b1;
                        end else if (period_ok) begin
                            div_busy  <= 1'b1;
                            div_cnt   <= 5'd27;
                            div_rem   <= '0;
                            div_quo   <= num;
                            div_under <= high_cnt < MIN_W;
                            div_w     <= high_cnt;
                            div_p     <= period_cnt;
                        end else begin
                            frame_err   <= 1'b1;
                            pulse_width <= high_cnt;
                            period      <= period_cnt;
                        end
                        high_cnt   <= 20'd1;
                        period_cnt <= 21'd1;
                        state      <= HIGH;
                    end else begin
                        period_cnt <= per_inc;
                    end
                end
                default: state <= WAIT_RISE;
            endcase

            // Loss of signal overrides everything and kills any division in flight.
            if (timeout_hit) begin
                signal_lost <= 1'b1;
                state       <= WAIT_RISE;
                high_cnt    <= '0;
                period_cnt  <= '0;
                div_busy    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder with scaled-down timing parameters so full frames stay short.
module tb_servo_pwm_decoder;

    localparam int unsigned MIN_W = 500;
    localparam int unsigned MAX_W = 1000;
    localparam int unsigned P_MIN = 4500;
    localparam int unsigned P_MAX = 5500;
    localparam int unsigned T_OUT = 6000;
`ifdef PWM_DEC_GLITCH_FILTER_EN
    localparam int FL = 4;
`else
    localparam int FL = 0;
`endif
    localparam int LAT_SV = 32 + FL;
    localparam int LAT_FE = 4 + FL;
    localparam int LAT_SL = int'(T_OUT) + 3 + FL;

    logic        clk = 1'b0;
    logic        reset;
    logic        pwm_in;
    logic [7:0]  angle;
    logic [19:0] pulse_width;
    logic [20:0] period;
    logic        sample_valid;
    logic        range_err;
    logic        frame_err;
    logic        signal_lost;

    servo_pwm_decoder #(
        .MIN_WIDTH (MIN_W),
        .MAX_WIDTH (MAX_W),
        .PERIOD_MIN(P_MIN),
        .PERIOD_MAX(P_MAX),
        .TIMEOUT   (T_OUT),
        .FILTER_LEN(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .angle       (angle),
        .pulse_width (pulse_width),
        .period      (period),
        .sample_valid(sample_valid),
        .range_err   (range_err),
        .frame_err   (frame_err),
        .signal_lost (signal_lost)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // What the last run_frame call observed, cycle numbers relative to its opening rise.
    int          sv_c, fe_c, sv_n, fe_n, sl_rise, sl_fall;
    logic [7:0]  cap_a, fcap_a;
    logic [19:0] cap_w, fcap_w;
    logic [20:0] cap_p, fcap_p;
    logic        cap_re;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_angle"}, 32'(angle), 0);
        check({tag, "_pw"},    32'(pulse_width), 0);
        check({tag, "_per"},   32'(period), 0);
        check({tag, "_sv"},    32'(sample_valid), 0);
        check({tag, "_re"},    32'(range_err), 0);
        check({tag, "_fe"},    32'(frame_err), 0);
        check({tag, "_sl"},    32'(signal_lost), 0);
    endtask

    // Rise at cycle 0, high for h cycles (optional 2-cycle low glitch at gpos), next rise at cycle p.
    task automatic run_frame(input int h, input int p, input int gpos);
        logic sl_prev;
        @(posedge clk);
        #1 pwm_in = 1'b1;
        sv_c = -1; fe_c = -1; sv_n = 0; fe_n = 0; sl_rise = -1; sl_fall = -1;
        sl_prev = signal_lost;
        for (int c = 1; c < p; c++) begin
            @(posedge clk);
            #1;
            if (gpos > 0 && c == gpos)     pwm_in = 1'b0;
            if (gpos > 0 && c == gpos + 2) pwm_in = 1'b1;
            if (c == h)                    pwm_in = 1'b0;
            if (sample_valid) begin
                sv_n++;
                if (sv_c < 0) begin
                    sv_c = c; cap_a = angle; cap_w = pulse_width; cap_p = period; cap_re = range_err;
                end
            end
            if (frame_err) begin
                fe_n++;
                if (fe_c < 0) begin
                    fe_c = c; fcap_a = angle; fcap_w = pulse_width; fcap_p = period;
                end
            end
            if (signal_lost && !sl_prev && sl_rise < 0) sl_rise = c;
            if (!signal_lost && sl_prev && sl_fall < 0) sl_fall = c;
            sl_prev = signal_lost;
        end
    endtask

    task automatic expect_sample(input string tag, input int a, input int w, input int p, input int re);
        check({tag, "_lat"},   32'(sv_c), 32'(LAT_SV));
        check({tag, "_nsv"},   32'(sv_n), 1);
        check({tag, "_nfe"},   32'(fe_n), 0);
        check({tag, "_angle"}, 32'(cap_a), 32'(a));
        check({tag, "_pw"},    32'(cap_w), 32'(w));
        check({tag, "_per"},   32'(cap_p), 32'(p));
        check({tag, "_re"},    32'(cap_re), 32'(re));
    endtask

    task automatic expect_ferr(input string tag, input int a, input int w, input int p, input int lat);
        check({tag, "_fe_lat"}, 32'(fe_c), 32'(lat));
        check({tag, "_nfe"},    32'(fe_n), 1);
        check({tag, "_nsv"},    32'(sv_n), 0);
        check({tag, "_angle"},  32'(fcap_a), 32'(a));
        check({tag, "_pw"},     32'(fcap_w), 32'(w));
        check({tag, "_per"},    32'(fcap_p), 32'(p));
    endtask

    task automatic expect_none(input string tag);
        check({tag, "_nsv"}, 32'(sv_n), 0);
        check({tag, "_nfe"}, 32'(fe_n), 0);
    endtask

    initial begin
        int n_sv, n_fe;
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 check_all_zero("rst_hold");
        reset = 1'b0;
        @(posedge clk);
        #1 check_all_zero("rst_rel");

        // Nominal frames: 750 high -> 90 degrees; 1083 -> 209; short period -> frame error.
        run_frame(750, 5000, 0);   expect_none("f0_arm");
        run_frame(750, 5000, 0);   expect_sample("f1", 90, 750, 5000, 0);
        run_frame(1083, 5000, 0);  expect_sample("f2", 90, 750, 5000, 0);
        run_frame(600, 2500, 0);   expect_sample("f3", 209, 1083, 5000, 0);
        run_frame(400, 5000, 0);   expect_ferr("f4", 209, 600, 2500, LAT_FE);
        check("f4_angle_hold", 32'(angle), 209);
        check("f4_re_hold", 32'(range_err), 0);

        // Under-range width, then the line goes quiet long enough to declare loss.
        run_frame(750, 7000, 0);   expect_sample("f5", 0, 400, 5000, 1);
        check("lost_lat", 32'(sl_rise), 32'(LAT_SL));
        run_frame(1300, 5000, 0);  expect_none("f6_arm");
        check("lost_hold_arm", 32'(signal_lost), 1);
        run_frame(750, 5000, 0);   expect_sample("f7", 255, 1300, 5000, 1);
        check("lost_hold_rerr", 32'(signal_lost), 1);
        run_frame(750, 5000, 0);   expect_sample("f8", 90, 750, 5000, 0);
        check("lost_clr_lat", 32'(sl_fall), 32'(LAT_SV));
        check("lost_clr", 32'(signal_lost), 0);

        // Reset lands on the divider's 15th step (close at cycle 4, steps from cycle 5).
        @(posedge clk);
        #1 pwm_in = 1'b1;
        n_sv = 0; n_fe = 0;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk);
            #1;
            if (sample_valid) n_sv++;
            if (c == 18 + FL) begin
                reset  = 1'b1;
                pwm_in = 1'b0;
            end
        end
        for (int c = 0; c < FL; c++) begin
            @(posedge clk);
            #1;
            if (sample_valid) n_sv++;
            if (c == FL - 1) begin
                reset  = 1'b1;
                pwm_in = 1'b0;
            end
        end
        @(posedge clk);
        #1 reset = 1'b0;
        check_all_zero("mid_div_rst");
        check("mid_div_rst_state", 32'(dut.state), 0);
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (sample_valid) n_sv++;
            if (frame_err) n_fe++;
        end
        check("mid_div_rst_nsv", 32'(n_sv), 0);
        check("mid_div_rst_nfe", 32'(n_fe), 0);
        check("mid_div_rst_idle", 32'(dut.state), 0);

        // Two-cycle low glitch inside the high pulse.
        run_frame(750, 5000, 300);
`ifdef PWM_DEC_GLITCH_FILTER_EN
        expect_none("g0_filtered");
        run_frame(750, 200, 0);    expect_sample("g1", 90, 750, 5000, 0);
`else
        expect_ferr("g0_glitch", 0, 300, 302, 302 + LAT_FE);
        run_frame(750, 200, 0);    expect_sample("g1", 0, 448, 4698, 1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/servo_pwm_decoder.md
# servo_pwm_decoder

Receive-side counterpart of the servo PWM generator: measures an incoming hobby-servo PWM signal and recovers the commanded angle. Synchronises `pwm_in`, measures high time and frame period in `clk` cycles, validates both, and converts high time to an 8-bit angle with an iterative divider. Sits between a servo-signal input pin, or a loopback from the generator, and any logic that needs the decoded angle.

## Interface
- `MIN_WIDTH`, 50000: high-time cycles for angle 0 (1 ms at 50 MHz)
- `MAX_WIDTH`, 100000: high-time cycles for angle 180 (2 ms)
- `PERIOD_MIN`, 900000: shortest accepted frame period, cycles
- `PERIOD_MAX`, 1100000: longest accepted frame period, cycles
- `TIMEOUT`, 2000000: cycles without a rising edge before signal loss
- `FILTER_LEN`, 4: glitch-filter depth, only used with the filter compiled in
- `clk`  in  1  system clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `pwm_in`  in  1  asynchronous servo PWM input
- `angle`  out  8  decoded angle in degrees, saturating
- `pulse_width`  out  20  high time of the last complete frame, cycles
- `period`  out  21  rising-edge-to-rising-edge time of the last frame, cycles
- `sample_valid`  out  1  one-cycle strobe when the outputs update
- `range_err`  out  1  qualifies `sample_valid`: width outside [MIN_WIDTH, 255-degree width]
- `frame_err`  out  1  one-cycle strobe: period outside [PERIOD_MIN, PERIOD_MAX]
- `signal_lost`  out  1  level: no rising edge for TIMEOUT cycles

## Operation
- Input path: 2-flop synchroniser, then the optional filter, then the edge detector (`rise`, `fall`).
- Measurement FSM:
  - WAIT_RISE (reset state): counters cleared. On `rise`, go to HIGH. This first edge only opens a frame.
  - HIGH: increment the high counter and the period counter. On `fall`, go to LOW.
  - LOW: increment the period counter. On `rise`, the frame is closed: latch high count and period, restart both counters at 1, go to HIGH.
  - A `rise` in HIGH is impossible after edge detection. Ignore it.
- Frame close:
  - If the period is in [PERIOD_MIN, PERIOD_MAX], start the divider.
  - Otherwise pulse `frame_err` the next cycle, update `pulse_width` and `period`, and leave `angle` unchanged with no `sample_valid`.
- Divider:
  - Computes angle = floor((w − MIN_WIDTH) × 180 / (MAX_WIDTH − MIN_WIDTH)) with a 28-bit shift-subtract algorithm, 1 bit per cycle, 28 cycles.
  - Runs in parallel with the next frame's HIGH count.
  - If w < MIN_WIDTH: angle = 0 and `range_err` = 1; the divider still takes 28 cycles.
  - If the quotient > 255: angle = 255 and `range_err` = 1.
  - A frame close while the divider is busy is impossible for a legal period. Handle it by dropping the new frame and raising `frame_err`.
- Counters:
  - Both saturate at all-ones, with no wrap.
  - If the period counter reaches TIMEOUT, set `signal_lost`, go to WAIT_RISE, abort the divider and suppress its strobe.
  - `signal_lost` clears on the next `sample_valid` with `range_err` = 0.
- Reset, including mid-frame or mid-divide: FSM to WAIT_RISE, divider idle.
- Output reset values: `angle` 0, `pulse_width` 0, `period` 0, `sample_valid` 0, `range_err` 0, `frame_err` 0, `signal_lost` 0.

## Timing
- Edge detection lags `pwm_in` by 3 cycles: 2 synchroniser cycles plus 1 edge-register cycle. Add FILTER_LEN cycles when the filter is compiled in.
- Measured width and period are exact because both edges carry the same lag.
- `sample_valid` and the new `angle`, `pulse_width`, `period` and `range_err` appear together, exactly 32 cycles after the closing `pwm_in` rise (32 + FILTER_LEN with the filter). All hold until the next update.
- `frame_err` asserts 4 cycles after the closing rise (plus FILTER_LEN with the filter).
- `signal_lost` rises on the cycle the period counter equals TIMEOUT.

## Configuration
- `PWM_DEC_GLITCH_FILTER_EN` defined:
  - The synchronised input feeds a FILTER_LEN-deep filter.
  - The filtered level changes only after FILTER_LEN consecutive equal samples.
  - Pulses shorter than FILTER_LEN cycles are invisible.
- Not defined: no filter. `FILTER_LEN` is ignored and every synchronised transition is an edge.

## Test plan
- Default parameters, 20 ms frames (1,000,000 cycles) with 75000 cycles high:
  - The first frame after reset produces no strobe.
  - From the second rise on, `sample_valid` fires 32 cycles after each rise with `angle`=90, `pulse_width`=75000, `period`=1000000, `range_err`=0.
- Loopback from the generator at angle 210 (high time 108333):
  - `angle`=209, `range_err`=0.
  - With high time 40000: `angle`=0, `range_err`=1.
- Period of 500000 cycles with 60000 high: `frame_err` strobes, `period`=500000, `angle` keeps its previous value, no `sample_valid`.
- `pwm_in` held low after valid frames:
  - `signal_lost`=1 exactly TIMEOUT cycles after the last rise.
  - After the next rise only arms; `signal_lost` stays 1. It clears after one further valid frame's strobe.
- Assert `reset` during the divider's 15th cycle: no strobe, all outputs 0 the next cycle, FSM in WAIT_RISE.
- With `PWM_DEC_GLITCH_FILTER_EN` and FILTER_LEN=4:
  - A 2-cycle low glitch inside the 75000-cycle high pulse: `pulse_width`=75000, latency 36.
  - Without the macro the same glitch yields a short `pulse_width` and a `frame_err`.
